// File: rtl/enc4x2_fifo_if.sv
// Handshake bundle for enc4x2_fifo: valid/ready input stream carrying x and
// valid/ready output stream carrying the encoded FIFO head.
interface enc4x2_fifo_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] x;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] y;
  logic       y_zero;
  logic       y_multi;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y, y_zero, y_multi
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y, y_zero, y_multi
  );
endinterface

// File: rtl/enc4x2_fifo.sv
// Registered 4-to-2 priority encoder feeding a DEPTH-entry output FIFO.
// Optional saturating error counter enabled by defining ENC_ERR_CNT_EN.
module enc4x2_fifo #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  enc4x2_fifo_if.slave     bus,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       fsm_state
);
  // Both streams: a transfer happens on a rising edge where valid && ready;
  // ready never depends combinationally on the opposite side's valid/ready.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {EMPTY = 2'd0, PART = 2'd1, FULL = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [3:0]      mem [DEPTH];
  logic            push, pop;
  logic [1:0]      enc_y;
  logic            enc_zero, enc_multi;

  always_comb begin
    enc_y = 2'd0;
    if (bus.x[3])      enc_y = 2'd3;
    else if (bus.x[2]) enc_y = 2'd2;
    else if (bus.x[1]) enc_y = 2'd1;
    enc_zero  = (bus.x == 4'd0);
    // Clearing the lowest set bit leaves something only if two or more were set.
    enc_multi = ((bus.x & (bus.x - 4'd1)) != 4'd0);
  end

  assign bus.in_ready  = rst_n && en && (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;
  assign {bus.y, bus.y_zero, bus.y_multi} = mem[rd_ptr];
  assign fsm_state = state_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          count_d = CW'(1);
          state_d = PART;
        end
      end
      PART: begin
        if (push && !pop) begin
          count_d = count_q + CW'(1);
          state_d = (count_d == DEPTH_C) ? FULL : PART;
        end else if (!push && pop) begin
          count_d = count_q - CW'(1);
          state_d = (count_d == '0) ? EMPTY : PART;
        end
      end
      FULL: begin
        if (pop) begin
          count_d = count_q - CW'(1);
          state_d = PART;
        end
      end
      default: begin
        state_d = EMPTY;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 4'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) begin
        mem[wr_ptr] <= {enc_y, enc_zero, enc_multi};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

`ifdef ENC_ERR_CNT_EN
  logic [CNT_W-1:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (push && (enc_zero || enc_multi) && (err_q != {CNT_W{1'b1}})) begin
      err_q <= err_q + CNT_W'(1);
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif
endmodule
